// File: rtl/universal_shift_reg.sv
// ---------------------------------------------------------------------------
// universal_shift_reg
//
// WIDTH-bit universal shift register with true and complementary outputs.
// Single-cycle commands: hold, parallel load and clear. Multi-cycle commands:
// shift left, shift right, rotate left, rotate right and mode 110. A
// multi-cycle command moves the word one bit per clock for a programmable
// number of steps.
//
// Handshake (valid/ready):
//   start/mode/amount/din form the command. The command is taken on a rising
//   clk edge when start=1 and busy=0, so busy=0 acts as "ready". While busy=1,
//   start is ignored and mode/amount/din are not sampled. done pulses for
//   exactly one cycle when a command completes. A new start may be presented
//   in the same cycle that done is high.
//
// Optional feature (compile-time macro USR_ASR_EN):
//   defined   -> mode 110 is an arithmetic shift right (the MSB is replicated)
//   undefined -> mode 110 behaves exactly like SHR (sin_l enters the MSB)
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   command strobe, sampled when idle
//   mode    in   3-bit command code, sampled with start
//   amount  in   CNT_W-bit shift count, sampled with start (saturates at WIDTH)
//   din     in   WIDTH-bit parallel load data
//   sin_l   in   serial input entering the MSB (SHR), sampled on every step
//   sin_r   in   serial input entering the LSB (SHL), sampled on every step
//   q       out  register contents
//   q_n     out  bitwise complement of q
//   sout_l  out  q[WIDTH-1]
//   sout_r  out  q[0]
//   busy    out  multi-cycle shift in progress (FSM is in SHIFT)
//   done    out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module universal_shift_reg #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] din,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_ROR   = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nx;
    logic [2:0]       smode;
    logic [2:0]       smode_nx;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nx;
    logic             done_r;
    logic             done_nx;

    // One single-bit move of the word for a shift/rotate mode.
    function automatic logic [WIDTH-1:0] step_one(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] v,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] r;
        r = v;
        case (m)
            M_SHL: r = {v[WIDTH-2:0], sr};
            M_SHR: r = {sl, v[WIDTH-1:1]};
            M_ROL: r = {v[WIDTH-2:0], v[WIDTH-1]};
            M_ROR: r = {v[0], v[WIDTH-1:1]};
`ifdef USR_ASR_EN
            M_ASR: r = {v[WIDTH-1], v[WIDTH-1:1]};
`else
            M_ASR: r = {sl, v[WIDTH-1:1]};
`endif
            default: r = v;
        endcase
        return r;
    endfunction

    // State register (FSM state plus datapath registers).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            smode  <= M_HOLD;
            q_r    <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nx;
            count  <= count_nx;
            smode  <= smode_nx;
            q_r    <= q_nx;
            done_r <= done_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        count_nx = count;
        smode_nx = smode;
        q_nx     = q_r;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (mode)
                        M_HOLD: done_nx = 1'b1;
                        M_LOAD: begin
                            q_nx    = din;
                            done_nx = 1'b1;
                        end
                        M_CLEAR: begin
                            q_nx    = '0;
                            done_nx = 1'b1;
                        end
                        default: begin
                            // Zero-length shift completes at once with q untouched.
                            if (amount == '0) begin
                                done_nx = 1'b1;
                            end else begin
                                state_nx = SHIFT;
                                smode_nx = mode;
                                count_nx = (amount > WIDTH_C) ? WIDTH_C : amount;
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                // count is at least 1 here; the step taken at count==1 is the last.
                q_nx     = step_one(smode, q_r, sin_l, sin_r);
                count_nx = count - ONE_C;
                if (count == ONE_C) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy   = (state == SHIFT);
        done   = done_r;
        q      = q_r;
        q_n    = ~q_r;
        sout_l = q_r[WIDTH-1];
        sout_r = q_r[0];
    end

endmodule

// File: tb/tb_universal_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_universal_shift_reg
//
// Bench for universal_shift_reg (WIDTH=8). A behavioural model tracks the
// expected word as an integer plus the number of shift steps still owed;
// every falling clock edge compares all outputs with it. Directed sequences
// add fixed expected values for the key scenarios, followed by a random run.
// ---------------------------------------------------------------------------
module tb_universal_shift_reg;

    localparam int W     = 8;
    localparam int CNT_W = $clog2(W + 1);
    localparam int MASK  = (1 << W) - 1;
    localparam int MSB   = 1 << (W - 1);

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic             start  = 1'b0;
    logic [2:0]       mode   = 3'b000;
    logic [CNT_W-1:0] amount = '0;
    logic [W-1:0]     din    = '0;
    logic             sin_l  = 1'b0;
    logic             sin_r  = 1'b0;
    logic [W-1:0]     q;
    logic [W-1:0]     q_n;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    universal_shift_reg #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mode   (mode),
        .amount (amount),
        .din    (din),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q      (q),
        .q_n    (q_n),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int m_q    = 0;   // expected word
    int m_left = 0;   // shift steps still owed
    int m_mode = 0;   // mode of the shift in progress
    int m_n    = 0;
    bit m_done = 0;

    function automatic int step(input int md, input int v, input int sl, input int sr);
        case (md)
            2: return ((v << 1) | sr) & MASK;
            3: return (v >> 1) | (sl * MSB);
            4: return ((v << 1) | (v >> (W - 1))) & MASK;
            5: return (v >> 1) | ((v & 1) * MSB);
`ifdef USR_ASR_EN
            6: return (v >> 1) | (v & MSB);
`else
            6: return (v >> 1) | (sl * MSB);
`endif
            default: return v;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q = 0; m_left = 0; m_done = 0;
        end else if (m_left > 0) begin
            m_q = step(m_mode, m_q, int'(sin_l), int'(sin_r));
            m_left--;
            m_done = (m_left == 0);
        end else begin
            m_done = 0;
            if (start) begin
                case (int'(mode))
                    0: m_done = 1;
                    1: begin m_q = int'(din); m_done = 1; end
                    7: begin m_q = 0; m_done = 1; end
                    default: begin
                        m_n = (int'(amount) > W) ? W : int'(amount);
                        if (m_n == 0) m_done = 1;
                        else begin m_left = m_n; m_mode = int'(mode); end
                    end
                endcase
            end
        end
    end

    // Scoreboard: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        check("q", 32'(q), 32'(m_q));
        check("q_n", 32'(q_n), 32'((~m_q) & MASK));
        check("sout_l", 32'(sout_l), 32'((m_q >> (W - 1)) & 1));
        check("sout_r", 32'(sout_r), 32'(m_q & 1));
        check("busy", 32'(busy), 32'(m_left > 0));
        check("done", 32'(done), 32'(m_done));
        check("busy_done_excl", 32'(busy & done), 32'(0));
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [2:0] m, input int a, input logic [W-1:0] d);
        start  = 1'b1;
        mode   = m;
        amount = a[CNT_W-1:0];
        din    = d;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic run_shift(output int cyc);
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        check("shift_timeout", 32'(busy), 32'(0));
    endtask

    int cyc;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_q", 32'(q), 32'h00);
        check("rst_q_n", 32'(q_n), 32'hFF);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // LOAD A5
        issue(3'b001, 0, 8'hA5);
        check("load_q", 32'(q), 32'hA5);
        check("load_q_n", 32'(q_n), 32'h5A);
        check("load_done", 32'(done), 32'(1));
        check("load_busy", 32'(busy), 32'(0));
        check("load_sout_l", 32'(sout_l), 32'(1));
        check("load_sout_r", 32'(sout_r), 32'(1));
        @(negedge clk);
        check("load_done_end", 32'(done), 32'(0));

        // SHL 3 with sin_r=1
        sin_r = 1'b1;
        issue(3'b010, 3, 8'h00);
        check("shl_busy0", 32'(busy), 32'(1));
        check("shl_q0", 32'(q), 32'hA5);
        @(negedge clk); check("shl_q1", 32'(q), 32'h4B);
        @(negedge clk); check("shl_q2", 32'(q), 32'h97);
        @(negedge clk); check("shl_q3", 32'(q), 32'h2F);
        check("shl_done", 32'(done), 32'(1));
        check("shl_busy_end", 32'(busy), 32'(0));
        @(negedge clk);
        check("shl_done_end", 32'(done), 32'(0));

        // ROR by 8 and by 12 (clamped) restore the word
        issue(3'b101, 8, 8'h00);
        run_shift(cyc);
        check("ror8_cycles", 32'(cyc), 32'(8));
        check("ror8_q", 32'(q), 32'h2F);
        check("ror8_done", 32'(done), 32'(1));
        @(negedge clk);
        issue(3'b101, 12, 8'h00);
        run_shift(cyc);
        check("ror12_cycles", 32'(cyc), 32'(8));
        check("ror12_q", 32'(q), 32'h2F);
        @(negedge clk);

        // Mode 110 from 80 with sin_l=0
        issue(3'b001, 0, 8'h80);
        sin_l = 1'b0;
        issue(3'b110, 3, 8'h00);
        run_shift(cyc);
        check("m110_cycles", 32'(cyc), 32'(3));
`ifdef USR_ASR_EN
        check("m110_q", 32'(q), 32'hF0);
`else
        check("m110_q", 32'(q), 32'h10);
`endif
        @(negedge clk);

        // start during busy is ignored
        issue(3'b001, 0, 8'h3C);
        issue(3'b100, 4, 8'h00);
        @(negedge clk);
        start = 1'b1; mode = 3'b001; din = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        run_shift(cyc);
        check("rol_ignore_q", 32'(q), 32'hC3);
        check("rol_ignore_cycles", 32'(cyc), 32'(2));
        // zero-length SHR
        issue(3'b011, 0, 8'h00);
        check("shr0_q", 32'(q), 32'hC3);
        check("shr0_done", 32'(done), 32'(1));
        check("shr0_busy", 32'(busy), 32'(0));
        @(negedge clk);
        check("shr0_done_end", 32'(done), 32'(0));
        check("shr0_busy_end", 32'(busy), 32'(0));

        // Asynchronous reset in the middle of ROR 5
        issue(3'b001, 0, 8'h5A);
        issue(3'b101, 5, 8'h00);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_q", 32'(q), 32'h00);
        check("arst_q_n", 32'(q_n), 32'hFF);
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_done", 32'(done), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("arst_no_done", 32'(done), 32'(0));
        end

        // Random run
        repeat (600) begin
            start  = ($urandom_range(0, 2) == 0);
            mode   = 3'($urandom_range(0, 7));
            amount = CNT_W'($urandom_range(0, 15));
            din    = W'($urandom);
            sin_l  = 1'($urandom_range(0, 1));
            sin_r  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
